// File: rtl/ysyx_22050710_if_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the IF fetch sequencer.
package ysyx_22050710_if_fetch_ctrl_pkg;
    localparam int          FS_PC_WD        = 64;
    localparam int          FS_INST_WD      = 32;
    localparam int          FS_SRAM_ADDR_WD = 32;
    localparam logic [63:0] FS_PC_RESETVAL  = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fs_state_e;
endpackage

// File: rtl/ysyx_22050710_if_skidbuf.sv
// One-entry {pc, inst} holding slot used when the IF output register is stalled.
module ysyx_22050710_if_skidbuf
    import ysyx_22050710_if_fetch_ctrl_pkg::*;
#(
    parameter int PC_WD   = FS_PC_WD,
    parameter int INST_WD = FS_INST_WD
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [PC_WD-1:0]   i_pc,
    input  logic [INST_WD-1:0] i_inst,
    output logic               o_valid,
    output logic [PC_WD-1:0]   o_pc,
    output logic [INST_WD-1:0] o_inst
);
    logic               valid_q, valid_d;
    logic [PC_WD-1:0]   pc_q, pc_d;
    logic [INST_WD-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_push) begin
            valid_d = 1'b1;
            pc_d    = i_pc;
            inst_d  = i_inst;
        end else if (i_pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pc    = pc_q;
    assign o_inst  = inst_q;
endmodule

// File: rtl/ysyx_22050710_if_fetch_ctrl.sv
// Fetch sequencer: drives PC load and the instruction SRAM handshake, tracks
// redirects across an outstanding fetch, and hands instructions to ID.
module ysyx_22050710_if_fetch_ctrl
    import ysyx_22050710_if_fetch_ctrl_pkg::*;
#(
    parameter int               PC_WD        = FS_PC_WD,
    parameter logic [PC_WD-1:0] PC_RESETVAL  = PC_WD'(FS_PC_RESETVAL),
    parameter int               SRAM_ADDR_WD = FS_SRAM_ADDR_WD,
    parameter int               INST_WD      = FS_INST_WD
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [PC_WD-1:0]        i_dnpc,
    input  logic                    i_br_taken,
    input  logic [PC_WD-1:0]        i_br_target,
    output logic                    o_pc_load,
    output logic                    o_pc_br_taken,
    output logic [PC_WD-1:0]        o_pc_br_target,
    output logic                    o_mem_req,
    output logic [SRAM_ADDR_WD-1:0] o_mem_addr,
    input  logic                    i_mem_addr_ok,
    input  logic                    i_mem_data_ok,
    input  logic [INST_WD-1:0]      i_mem_rdata,
    output logic                    o_fs_valid,
    output logic [PC_WD-1:0]        o_fs_pc,
    output logic [INST_WD-1:0]      o_fs_inst,
    input  logic                    i_ds_allowin
);
    fs_state_e          state_q, state_d;
    logic               redir_pend_q, redir_pend_d;
    logic [PC_WD-1:0]   redir_tgt_q, redir_tgt_d;
    logic               cancel_q, cancel_d;
    logic               first_q, first_d;
    logic [PC_WD-1:0]   req_pc_q, req_pc_d;
    logic               fs_valid_q, fs_valid_d;
    logic [PC_WD-1:0]   fs_pc_q, fs_pc_d;
    logic [INST_WD-1:0] fs_inst_q, fs_inst_d;

    logic               skid_valid, skid_push, skid_pop;
    logic [PC_WD-1:0]   skid_pc;
    logic [INST_WD-1:0] skid_inst;

    logic               eff_taken, accept, deliver, out_free;
    logic [PC_WD-1:0]   eff_target, fetch_addr;

    assign eff_taken  = i_br_taken | redir_pend_q;
    assign eff_target = i_br_taken ? i_br_target : redir_tgt_q;
    assign fetch_addr = first_q ? PC_RESETVAL : (eff_taken ? eff_target : i_dnpc);
    assign o_mem_req  = (state_q == S_REQ) && !skid_valid;
    assign accept     = o_mem_req && i_mem_addr_ok;
    // A response arriving alongside a redirect is already stale.
    assign deliver    = (state_q == S_WAIT) && i_mem_data_ok && !cancel_q && !i_br_taken;
    assign out_free   = !fs_valid_q || i_ds_allowin;

    always_comb begin
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        cancel_d     = cancel_q;
        first_d      = first_q;
        req_pc_d     = req_pc_q;
        case (state_q)
            S_BOOT:  state_d = S_REQ;
            S_REQ:   if (accept) state_d = S_WAIT;
            S_WAIT:  if (i_mem_data_ok) state_d = S_REQ;
            default: state_d = S_BOOT;
        endcase
        // Acceptance consumes the pending redirect; a coincident redirect only
        // cancels the response of the request it rode on.
        if (accept) begin
            req_pc_d     = fetch_addr;
            redir_pend_d = 1'b0;
            first_d      = 1'b0;
            if (i_br_taken) cancel_d = 1'b1;
        end else if (i_br_taken) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = i_br_target;
        end
        if (state_q == S_WAIT) begin
            if (i_mem_data_ok)   cancel_d = 1'b0;
            else if (i_br_taken) cancel_d = 1'b1;
        end
    end

    always_comb begin
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        fs_inst_d  = fs_inst_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        if (i_br_taken) begin
            fs_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                skid_pop   = 1'b1;
                fs_valid_d = 1'b1;
                fs_pc_d    = skid_pc;
                fs_inst_d  = skid_inst;
            end else if (deliver) begin
                fs_valid_d = 1'b1;
                fs_pc_d    = req_pc_q;
                fs_inst_d  = i_mem_rdata;
            end else begin
                fs_valid_d = 1'b0;
            end
        end else if (deliver) begin
            skid_push = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_BOOT;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            cancel_q     <= 1'b0;
            first_q      <= 1'b1;
            req_pc_q     <= '0;
            fs_valid_q   <= 1'b0;
            fs_pc_q      <= '0;
            fs_inst_q    <= '0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            cancel_q     <= cancel_d;
            first_q      <= first_d;
            req_pc_q     <= req_pc_d;
            fs_valid_q   <= fs_valid_d;
            fs_pc_q      <= fs_pc_d;
            fs_inst_q    <= fs_inst_d;
        end
    end

    ysyx_22050710_if_skidbuf #(
        .PC_WD   (PC_WD),
        .INST_WD (INST_WD)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (skid_push),
        .i_pop   (skid_pop),
        .i_flush (i_br_taken),
        .i_pc    (req_pc_q),
        .i_inst  (i_mem_rdata),
        .o_valid (skid_valid),
        .o_pc    (skid_pc),
        .o_inst  (skid_inst)
    );

    assign o_pc_load      = accept;
    assign o_pc_br_taken  = eff_taken;
    assign o_pc_br_target = eff_target;
    // BOOT masks the address so every output reads zero while held in reset.
    assign o_mem_addr     = (state_q == S_BOOT) ? '0 : fetch_addr[SRAM_ADDR_WD-1:0];
    assign o_fs_valid     = fs_valid_q;
    assign o_fs_pc        = fs_pc_q;
    assign o_fs_inst      = fs_inst_q;

    a_data_ok_only_in_wait: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_mem_data_ok |-> (state_q == S_WAIT));
endmodule

// File: tb/tb_ysyx_22050710_if_fetch_ctrl.sv
// Directed plus random checks of the fetch sequencer against a bus/PC/ID model.
module tb_ysyx_22050710_if_fetch_ctrl;
    localparam logic [63:0] RV = 64'h8000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] i_dnpc = '0, i_br_target = '0;
    logic        i_br_taken = 1'b0, i_mem_addr_ok = 1'b0, i_mem_data_ok = 1'b0, i_ds_allowin = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_pc_load, o_pc_br_taken, o_mem_req, o_fs_valid;
    logic [63:0] o_pc_br_target, o_fs_pc;
    logic [31:0] o_mem_addr, o_fs_inst;

    ysyx_22050710_if_fetch_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dnpc(i_dnpc), .i_br_taken(i_br_taken),
        .i_br_target(i_br_target), .o_pc_load(o_pc_load), .o_pc_br_taken(o_pc_br_taken),
        .o_pc_br_target(o_pc_br_target), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_addr_ok(i_mem_addr_ok), .i_mem_data_ok(i_mem_data_ok), .i_mem_rdata(i_mem_rdata),
        .o_fs_valid(o_fs_valid), .o_fs_pc(o_fs_pc), .o_fs_inst(o_fs_inst), .i_ds_allowin(i_ds_allowin)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    int          aok_dly = 0, dok_dly = 0, wcnt = 0, rcnt = 0, rwait = 0, loads = 0, req_cycles = 0;
    bit          allow_rand = 0, allow_fix = 1, rand_bus = 0, outst = 0, hold = 0;
    logic [31:0] out_addr = '0, hold_addr = '0;
    logic [63:0] pc_reg = RV - 64'd4;
    logic [63:0] exp_pc = RV;
    logic [63:0] reqs[$];
    logic [63:0] seen[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One clock: drive inputs after the edge, observe handshakes, advance models.
    // mode: 0 none, 1 redirect now, 2 redirect on acceptance, 3 random redirect.
    task automatic cyc(input int mode, input logic [63:0] tgt, output bit fired);
        bit          br;
        logic [63:0] t;
        t = tgt;
        i_dnpc = pc_reg + 64'd4;
        i_ds_allowin = allow_rand ? 1'($urandom_range(0, 1)) : allow_fix;
        if (rand_bus) i_mem_addr_ok = o_mem_req && ($urandom_range(0, 2) == 0);
        else          i_mem_addr_ok = o_mem_req && (wcnt >= aok_dly);
        i_mem_data_ok = outst && (rcnt >= rwait);
        i_mem_rdata = i_mem_data_ok ? inst_of(out_addr) : $urandom;
        case (mode)
            1:       br = 1'b1;
            2:       br = o_mem_req && i_mem_addr_ok;
            3:       br = !(o_mem_req && i_mem_addr_ok) && !i_mem_data_ok && ($urandom_range(0, 7) == 0);
            default: br = 1'b0;
        endcase
        if (mode == 3) t = RV + 64'({$urandom_range(0, 255), 2'b00});
        i_br_taken = br;
        i_br_target = br ? t : '0;
        fired = br;
        #2;
        if (outst) chk("one_outstanding", o_mem_req, 0);
        if (o_mem_req && hold && !br) chk("addr_stable", o_mem_addr, hold_addr);
        chk("pc_load", o_pc_load, o_mem_req && i_mem_addr_ok);
        if (o_mem_req) req_cycles++;
        if (i_mem_data_ok) outst = 0;
        else if (outst) rcnt++;
        if (o_mem_req && i_mem_addr_ok) begin
            reqs.push_back({32'h0, o_mem_addr});
            outst = 1; rcnt = 0; wcnt = 0; hold = 0; out_addr = o_mem_addr;
            rwait = rand_bus ? int'($urandom_range(0, 3)) : dok_dly;
        end else if (o_mem_req) begin
            wcnt++; hold = 1; hold_addr = o_mem_addr;
        end else hold = 0;
        if (o_pc_load) begin
            loads++;
            pc_reg = o_pc_br_taken ? o_pc_br_target : i_dnpc;
        end
        if (o_fs_valid) chk("inst_match", {32'h0, o_fs_inst}, {32'h0, inst_of(o_fs_pc[31:0])});
        if (o_fs_valid && i_ds_allowin) begin
            chk("fs_order", o_fs_pc, exp_pc);
            seen.push_back(o_fs_pc);
            exp_pc = exp_pc + 64'd4;
        end
        if (br) exp_pc = t;
        @(posedge clk); #1;
    endtask

    task automatic run_reqs(input int n);
        bit f;
        for (int k = 0; k < 60 && reqs.size() < n; k++) cyc(0, '0, f);
        chk("reqs_reached", 64'(reqs.size() >= n), 1);
    endtask

    task automatic run_seen(input int n);
        bit f;
        for (int k = 0; k < 60 && seen.size() < n; k++) cyc(0, '0, f);
        chk("seen_reached", 64'(seen.size() >= n), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load"}, o_pc_load, 0);
        chk({tag, "_brt"}, o_pc_br_taken, 0);
        chk({tag, "_brtgt"}, o_pc_br_target, 0);
        chk({tag, "_req"}, o_mem_req, 0);
        chk({tag, "_addr"}, o_mem_addr, 0);
        chk({tag, "_valid"}, o_fs_valid, 0);
        chk({tag, "_pc"}, o_fs_pc, 0);
        chk({tag, "_inst"}, o_fs_inst, 0);
    endtask

    task automatic model_reset();
        outst = 0; hold = 0; wcnt = 0; rcnt = 0;
        pc_reg = RV - 64'd4;
        exp_pc = RV;
    endtask

    initial begin
        bit f;
        int n, r;
        // reset state
        #12;
        chk_all_zero("rst");
        @(negedge clk); rst_n = 1'b1; #1;
        chk("boot_req", o_mem_req, 0);
        @(posedge clk); #1;

        // back-to-back fetch, first-response latency
        cyc(0, '0, f);
        chk("req0_addr", reqs[0], RV);
        chk("wait_novalid", o_fs_valid, 0);
        cyc(0, '0, f);
        chk("lat_valid", o_fs_valid, 1);
        chk("lat_pc", o_fs_pc, RV);
        chk("lat_inst", {32'h0, o_fs_inst}, {32'h0, inst_of(RV[31:0])});
        cyc(0, '0, f);
        chk("req1_addr", reqs[1], RV + 64'd4);
        chk("loads_a", loads, 2);

        // addr_ok held off three cycles
        aok_dly = 3; loads = 0; req_cycles = 0;
        run_reqs(3);
        chk("req2_addr", reqs[2], RV + 64'd8);
        chk("req2_cycles", req_cycles, 4);
        chk("req2_loads", loads, 1);
        chk("seen0", seen[0], RV);
        chk("seen1", seen[1], RV + 64'd4);

        // redirect while waiting on 0x8000000C
        aok_dly = 0; dok_dly = 3;
        run_reqs(4);
        chk("req3_addr", reqs[3], RV + 64'hC);
        n = seen.size();
        cyc(1, RV + 64'h100, f);
        dok_dly = 0;
        run_reqs(5);
        chk("redir_req", reqs[4], RV + 64'h100);
        run_seen(n + 1);
        chk("redir_first", seen[n], RV + 64'h100);

        // ID stalls: output register and skid fill, request held off
        allow_fix = 0;
        repeat (8) cyc(0, '0, f);
        chk("stall_req", o_mem_req, 0);
        chk("stall_valid", o_fs_valid, 1);
        r = reqs.size();
        repeat (2) cyc(0, '0, f);
        chk("stall_noreq", reqs.size(), r);
        allow_fix = 1;
        n = seen.size();
        run_seen(n + 3);
        chk("drain1", seen[n + 1], seen[n] + 64'd4);
        chk("drain2", seen[n + 2], seen[n] + 64'd8);

        // redirect coincident with acceptance
        r = reqs.size();
        f = 0;
        for (int k = 0; k < 20 && !f; k++) cyc(2, RV + 64'h100, f);
        chk("coinc_fired", f, 1);
        chk("coinc_addr", reqs[r], RV + 64'h100);
        chk("coinc_pcreg", pc_reg, RV + 64'h100);
        exp_pc = RV + 64'h104;
        n = seen.size();
        run_reqs(r + 2);
        chk("coinc_next", reqs[r + 1], RV + 64'h104);
        run_seen(n + 1);
        chk("coinc_seen", seen[n], RV + 64'h104);

        // asynchronous reset in the middle of WAIT
        dok_dly = 4;
        run_reqs(reqs.size() + 1);
        i_br_taken = 0; i_br_target = '0; i_mem_addr_ok = 0; i_mem_data_ok = 0; i_ds_allowin = 0;
        #1 rst_n = 1'b0; #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        model_reset();
        dok_dly = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        r = reqs.size();
        run_reqs(r + 1);
        chk("post_rst_addr", reqs[r], RV);

        // randomized bus timing, ID backpressure and redirects
        rand_bus = 1; allow_rand = 1;
        n = seen.size();
        repeat (2000) cyc(3, '0, f);
        chk("rand_progress", 64'(seen.size() - n >= 50), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
